// File: rtl/mult_pkg.sv
// Types and defaults shared by the pipelined multiplier and its CDB completion buffer.
package mult_pkg;

    localparam int MULT_LAT_DEF       = 4;
    localparam int MULT_BUF_DEPTH_DEF = 4;
    localparam int ROB_IDX_W          = 5;
    localparam int PRF_IDX_W          = 7;

    typedef struct packed {
        logic [63:0]          value;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PRF_IDX_W-1:0] dest_tag;
    } mult_result_t;

endpackage

// File: rtl/mult_cdb_buf_if.sv
// Multiplier-result / CDB / issue-credit bundle around the multiply completion buffer.
interface mult_cdb_buf_if import mult_pkg::*; #(
    parameter int DEPTH = MULT_BUF_DEPTH_DEF
);
    logic                   issue_i;
    logic                   flush_i;
    logic                   mult_done_i;
    logic [63:0]            mult_product_i;
    logic [ROB_IDX_W-1:0]   mult_rob_idx_i;
    logic [PRF_IDX_W-1:0]   mult_dest_tag_i;
    logic                   cdb_grant_i;
    logic                   cdb_req_o;
    logic [63:0]            cdb_value_o;
    logic [ROB_IDX_W-1:0]   cdb_rob_idx_o;
    logic [PRF_IDX_W-1:0]   cdb_tag_o;
    logic                   issue_stall_o;
    logic [$clog2(DEPTH):0] count_o;
    logic                   overflow_o;

    modport master (
        output issue_i, flush_i, mult_done_i, mult_product_i, mult_rob_idx_i,
               mult_dest_tag_i, cdb_grant_i,
        input  cdb_req_o, cdb_value_o, cdb_rob_idx_o, cdb_tag_o, issue_stall_o,
               count_o, overflow_o
    );

    modport slave (
        input  issue_i, flush_i, mult_done_i, mult_product_i, mult_rob_idx_i,
               mult_dest_tag_i, cdb_grant_i,
        output cdb_req_o, cdb_value_o, cdb_rob_idx_o, cdb_tag_o, issue_stall_o,
               count_o, overflow_o
    );

endinterface

// File: rtl/mult_cdb_buf_fifo.sv
// Synchronous FIFO whose head entry is held in a register, so readers see no RAM read path.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);
        count_nxt  = count + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            // Bypass the write data when it lands exactly in the next head slot.
            if (count_nxt != '0)
                head <= (do_push && (rd_ptr_nxt == wr_ptr)) ? wdata : mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mult_cdb_buf.sv
// Multiply completion buffer: captures live multiplier results, presents them to the CDB
// and withholds issue credit so the non-stalling multiplier always has a free slot.
module mult_cdb_buf import mult_pkg::*; #(
    parameter int DEPTH    = MULT_BUF_DEPTH_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF
) (
    input logic           clock,
    input logic           reset,
    mult_cdb_buf_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = $clog2(DEPTH + MULT_LAT + 1);

    logic [MULT_LAT-1:0] live_q;
    logic [MULT_LAT-1:0] live_nxt;
    logic [SUM_W-1:0]    inflight;
    logic [CNT_W-1:0]    count;
    logic                wr_en;
    logic                pop;
    logic                full;
    logic                empty;
    logic                overflow_q;
    mult_result_t        wr_res;
    mult_result_t        head_res;

    // Bit i set means a multiply issued i+1 cycles ago is still live; the tail matches mult_done_i.
    always_comb begin
        live_nxt    = live_q << 1;
        live_nxt[0] = bus.issue_i;
        inflight    = '0;
        for (int i = 0; i < MULT_LAT; i++) inflight = inflight + SUM_W'(live_q[i]);
    end

    always_ff @(posedge clock) begin
        if (reset || bus.flush_i) live_q <= '0;
        else                      live_q <= live_nxt;
    end

    assign wr_en = bus.mult_done_i & live_q[MULT_LAT-1] & ~bus.flush_i;
    assign pop   = ~empty & bus.cdb_grant_i & ~bus.flush_i;

    assign wr_res = '{value:    bus.mult_product_i,
                      rob_idx:  bus.mult_rob_idx_i,
                      dest_tag: bus.mult_dest_tag_i};

    always_ff @(posedge clock) begin
        if (reset)                       overflow_q <= 1'b0;
        else if (wr_en && full && !pop)  overflow_q <= 1'b1;
    end

    sync_fifo #(
        .WIDTH ($bits(mult_result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (bus.flush_i),
        .push  (wr_en),
        .pop   (pop),
        .wdata (wr_res),
        .head  (head_res),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Credit counts buffered plus in-flight results; a same-cycle pop is not credited yet.
    assign bus.issue_stall_o = (SUM_W'(count) + inflight) >= SUM_W'(DEPTH);
    assign bus.cdb_req_o     = ~empty;
    assign bus.cdb_value_o   = head_res.value;
    assign bus.cdb_rob_idx_o = head_res.rob_idx;
    assign bus.cdb_tag_o     = head_res.dest_tag;
    assign bus.count_o       = count;
    assign bus.overflow_o    = overflow_q;

endmodule

// File: doc/mult_cdb_buf.md
# mult_cdb_buf

Completion buffer between the pipelined integer multiplier and the CDB arbiter. The multiplier cannot stall, so every result it retires is captured here and held until the CDB grants it. The block also throttles multiply issue with a credit check, which guarantees a result always has a slot. It drops results belonging to squashed (flushed) multiplies.

## Interface
- `DEPTH`, 4: result entries; power of two, at least 2.
- `MULT_LAT`, 4: cycles from multiplier `start_i` to `done`; must equal the multiplier stage count.
- `clock`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `issue_i`  in  1: a multiply is started in the multiplier this cycle (same pulse as the multiplier's `start_i`).
- `flush_i`  in  1: squash all buffered and in-flight multiplies.
- `mult_done_i`  in  1: multiplier result valid this cycle.
- `mult_product_i`  in  64: multiplier product.
- `mult_rob_idx_i`  in  `ROB_IDX_W`: ROB index travelling with the result.
- `mult_dest_tag_i`  in  `PRF_IDX_W`: destination physical register tag.
- `cdb_grant_i`  in  1: arbiter grants the CDB to this unit this cycle.
- `cdb_req_o`  out  1: head entry valid, requesting the CDB.
- `cdb_value_o`  out  64: head product.
- `cdb_rob_idx_o`  out  `ROB_IDX_W`: head ROB index.
- `cdb_tag_o`  out  `PRF_IDX_W`: head destination tag.
- `issue_stall_o`  out  1: issue logic must not assert `issue_i`.
- `count_o`  out  $clog2(DEPTH)+1: buffered entries.
- `overflow_o`  out  1: sticky error; a live result arrived while the buffer was full.

## Operation
- Live tracker: a `MULT_LAT`-bit shift register.
  - Bit 0 is loaded with `issue_i & ~flush_i` each cycle; all bits shift by one per cycle.
  - The tail bit marks the multiply whose result is on `mult_done_i` this cycle.
- Capture rule: write when `mult_done_i & live_tail & ~flush_i`. Otherwise the result is dropped (squashed or spurious done).
- FIFO holds `{product, rob_idx, dest_tag}`. Head fields drive the `cdb_*` outputs directly from registers; there is no combinational path from `mult_*` to `cdb_*`.
- Pop when `cdb_req_o & cdb_grant_i`.
- Credit:
  - `inflight` is the popcount of the live tracker.
  - `issue_stall_o = (count + inflight) >= DEPTH`, computed from registered state only.
  - A pop in the current cycle does not relieve the stall until the next cycle.
- Simultaneous push and pop at any occupancy: both take effect and `count` is unchanged.
- Write when `count == DEPTH` with no pop in the same cycle: the result is dropped, `overflow_o` is set, and stays set until reset. This is unreachable if the credit is honoured.
- `flush_i` (same cycle):
  - Empties the FIFO, with pointers reset and `count = 0`.
  - Clears all live bits, and squashes `issue_i` of that cycle.
  - A grant in the flush cycle has no effect; the arbiter must tolerate the request dropping.
- Pointers wrap modulo `DEPTH`. Full and empty are distinguished by `count`.

## Timing
- Reset values: `cdb_req_o=0`, `cdb_value_o=0`, `cdb_rob_idx_o=0`, `cdb_tag_o=0`, `issue_stall_o=0`, `count_o=0`, `overflow_o=0`; live tracker all zero.
- Issue at cycle t: the result arrives with `mult_done_i` at t+`MULT_LAT`, is written at the end of that cycle, and `cdb_req_o=1` from t+`MULT_LAT`+1.
- Minimum latency from `mult_done_i` to `cdb_req_o` is 1 cycle.
- After a pop, the next entry appears on `cdb_*` in the following cycle, giving one completion per cycle back-to-back under continuous grant.
- `cdb_*` outputs are stable while `cdb_req_o=1` and no grant is given.
- Reset mid-operation: everything clears as at reset. Multiplier dones arriving after reset are dropped because their live bits are 0.

## Structure
- Shared package, `mult_pkg`:
  - Typedef `mult_result_t` with fields value[63:0], rob_idx, dest_tag.
  - Constants `MULT_LAT_DEF=4` and `MULT_BUF_DEPTH_DEF=4`.
  - The pipelined multiplier and this block both use them.
- One sub-module: `sync_fifo`, a parameterised width/depth synchronous FIFO with push, pop, clear, count, full, empty and registered head.
- `mult_cdb_buf` contains the live tracker, the credit logic, the overflow flag and the `sync_fifo` instance.

## Test plan
- Single op: issue at cycle 10 with product 0x1234, rob 3, tag 17, grant held high. Expect `mult_done_i` at cycle 14, `cdb_req_o` at cycle 15 showing 0x1234/3/17, and `count_o` returning to 0 at cycle 16.
- Back-to-back with no grant: issue on 4 consecutive cycles.
  - `issue_stall_o` rises once 4 ops are in flight or buffered, and `count_o` reaches 4.
  - Grants then pop 4 entries in issue order on consecutive cycles; stall drops in the cycle after the first pop.
- Flush with 2 entries buffered and 2 in flight: `count_o` is 0 next cycle, and both later dones are dropped with `cdb_req_o` staying 0.
- Push and pop in the same cycle at count 2: count stays 2 and order is preserved.
- Forced violation: drive `mult_done_i` with a live bit while count is 4 and no grant. Expect `overflow_o=1`, sticky, and buffer contents unchanged.
- Reset asserted at t+2 after an issue at t: the done at t+4 is ignored, and all outputs hold their reset values.
